// File: rtl/midi_rx_mmio.sv
// MIDI 8N1 serial receiver with a byte FIFO, read by the CPU through a DATA/STATUS dmem window.
// Optional build macro MIDI_FILTER_REALTIME_EN drops MIDI real-time bytes (0xF8-0xFF) before the FIFO.
module midi_rx_mmio #(
   parameter int          CLK_HZ     = 50000000,
   parameter int          BAUD       = 31250,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [11:0] BASE_ADDR  = 12'hFF0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        midi_rx,
   input  logic [11:0] addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        hit
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);

   localparam logic [11:0]      STATUS_ADDR = BASE_ADDR + 12'd1;
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [PTR_W:0]   DEPTH_C     = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   rx_state_t        state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [2:0]       bit_idx, bit_idx_d;
   logic [7:0]       shift, shift_d;
   logic             sync_1, rx_s;
   logic             rx_done, frame_set, is_rt, push;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             overrun, frame_err;
   logic             data_rd, status_rd, flush, empty, full, pop, do_push, overrun_set;
   logic [7:0]       count_byte;
   logic             unused_wr_bits;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_1 <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_1 <= midi_rx;
         rx_s   <= sync_1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_idx <= bit_idx_d;
         shift   <= shift_d;
      end
   end

   // Counting states sample rx_s when cnt reaches zero, otherwise they just count down.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      bit_idx_d = bit_idx;
      shift_d   = shift;
      rx_done   = 1'b0;
      frame_set = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = HALF_RELOAD;
            end
         end
         START: begin
            if (cnt == '0) begin
               if (!rx_s) begin
                  state_d   = DATA;
                  cnt_d     = BIT_RELOAD;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == '0) begin
               shift_d[bit_idx] = rx_s;
               cnt_d            = BIT_RELOAD;
               if (bit_idx == 3'd7) state_d = STOP;
               else bit_idx_d = bit_idx + 3'd1;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt == '0) begin
               state_d = IDLE;
               if (rx_s) rx_done = 1'b1;
               else frame_set = 1'b1;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef MIDI_FILTER_REALTIME_EN
   assign is_rt = (shift >= 8'hF8);
`else
   assign is_rt = 1'b0;
`endif

   assign push      = rx_done && !is_rt;
   assign data_rd   = rd_en && (addr == BASE_ADDR);
   assign status_rd = rd_en && (addr == STATUS_ADDR);
   assign flush     = wr_en && (addr == STATUS_ADDR) && wr_data[0];
   assign empty     = (count == '0);
   assign full      = (count == DEPTH_C);
   assign pop       = data_rd && !empty;
   // A flush wins over a simultaneous push: the byte is lost silently.
   assign do_push     = push && !flush && (!full || pop);
   assign overrun_set = push && !flush && full && !pop;
   assign count_byte  = 8'(count);
   assign unused_wr_bits = ^wr_data[31:1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !pop) count <= count + (PTR_W + 1)'(1);
         else if (pop && !do_push) count <= count - (PTR_W + 1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= shift;
   end

   // Sticky error flags clear on a STATUS read unless a new event lands in the same cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (overrun_set) overrun <= 1'b1;
         else if (status_rd) overrun <= 1'b0;
         if (frame_set) frame_err <= 1'b1;
         else if (status_rd) frame_err <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
         hit     <= 1'b0;
      end else begin
         hit <= data_rd || status_rd;
         if (data_rd)
            rd_data <= {23'b0, !empty, (empty ? 8'h00 : mem[rd_ptr])};
         else if (status_rd)
            rd_data <= {16'b0, count_byte, 4'b0, full, empty, overrun, frame_err};
         else
            rd_data <= '0;
      end
   end

endmodule

// File: tb/tb_midi_rx_mmio.sv
// Self-checking bench for midi_rx_mmio: a directed step table, hand-written reset/hit sequences,
// and randomized traffic checked against a queue-based model of the FIFO and error flags.
module tb_midi_rx_mmio;

   localparam int          FIFO_DEPTH = 16;
   localparam int          CPB        = 16;
   localparam logic [11:0] BASE       = 12'hFF0;
   localparam logic [11:0] STAT       = 12'hFF1;

`ifdef MIDI_FILTER_REALTIME_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        midi_rx = 1'b1;
   logic [11:0] addr = '0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic        hit;

   int checks = 0;
   int errors = 0;

   typedef enum {OP_SEND, OP_SEND_BAD, OP_GLITCH, OP_READ_DATA, OP_READ_STATUS, OP_FLUSH} op_t;
   typedef struct {
      op_t         op;
      logic [7:0]  b;
      logic [31:0] exp;
   } step_t;

   step_t      steps[$];
   logic [7:0] model_q[$];
   bit         model_ovr;
   bit         model_fe;

   midi_rx_mmio #(
      .CLK_HZ(500000), .BAUD(31250), .FIFO_DEPTH(FIFO_DEPTH), .BASE_ADDR(BASE)
   ) dut (
      .clock(clock), .reset(reset), .midi_rx(midi_rx), .addr(addr), .rd_en(rd_en),
      .wr_en(wr_en), .wr_data(wr_data), .rd_data(rd_data), .hit(hit)
   );

   always #5 clock = ~clock;

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_val);
      midi_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         midi_rx = b[i];
         tick(CPB);
      end
      midi_rx = stop_val;
      tick(CPB);
      midi_rx = 1'b1;
      if (!stop_val) tick(2 * CPB);
   endtask

   task automatic read_reg(input logic [11:0] a, output logic [31:0] d, output logic h);
      addr  = a;
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      d = rd_data;
      h = hit;
   endtask

   task automatic write_reg(input logic [11:0] a, input logic [31:0] d);
      addr    = a;
      wr_data = d;
      wr_en   = 1'b1;
      tick(1);
      wr_en   = 1'b0;
      wr_data = '0;
   endtask

   task automatic apply_stimulus(input step_t s, input int idx);
      logic [31:0] d;
      logic        h;
      case (s.op)
         OP_SEND:     send_frame(s.b, 1'b1);
         OP_SEND_BAD: send_frame(s.b, 1'b0);
         OP_GLITCH: begin
            midi_rx = 1'b0;
            tick(4);
            midi_rx = 1'b1;
            tick(2 * CPB);
         end
         OP_READ_DATA: begin
            read_reg(BASE, d, h);
            check_output($sformatf("step%0d_data", idx), d, s.exp);
            check_output($sformatf("step%0d_hit", idx), {31'b0, h}, 32'h1);
         end
         OP_READ_STATUS: begin
            read_reg(STAT, d, h);
            check_output($sformatf("step%0d_status", idx), d, s.exp);
            check_output($sformatf("step%0d_hit", idx), {31'b0, h}, 32'h1);
         end
         OP_FLUSH: write_reg(STAT, 32'h1);
         default: ;
      endcase
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] e;
      e       = '0;
      e[15:8] = 8'(model_q.size());
      e[3]    = (model_q.size() == FIFO_DEPTH);
      e[2]    = (model_q.size() == 0);
      e[1]    = model_ovr;
      e[0]    = model_fe;
      return e;
   endfunction

   task automatic model_send(input logic [7:0] b);
      if (FILTER && b >= 8'hF8) return;
      if (model_q.size() == FIFO_DEPTH) model_ovr = 1'b1;
      else model_q.push_back(b);
   endtask

   initial begin
      logic [31:0] d;
      logic        h;
      logic [31:0] e;
      logic [7:0]  b;
      int          r;

      // Directed table.
      steps.push_back('{OP_READ_STATUS, 8'h00, 32'h0000_0004});
      steps.push_back('{OP_SEND, 8'h90, 32'h0});
      steps.push_back('{OP_SEND, 8'h3C, 32'h0});
      steps.push_back('{OP_SEND, 8'h7F, 32'h0});
      steps.push_back('{OP_READ_STATUS, 8'h00, 32'h0000_0300});
      steps.push_back('{OP_READ_DATA, 8'h00, 32'h0000_0190});
      steps.push_back('{OP_READ_DATA, 8'h00, 32'h0000_013C});
      steps.push_back('{OP_READ_DATA, 8'h00, 32'h0000_017F});
      steps.push_back('{OP_READ_DATA, 8'h00, 32'h0000_0000});
      for (int i = 0; i < 17; i++) steps.push_back('{OP_SEND, 8'(i), 32'h0});
      steps.push_back('{OP_READ_STATUS, 8'h00, 32'h0000_100A});
      for (int i = 0; i < 16; i++) steps.push_back('{OP_READ_DATA, 8'h00, 32'h100 + 32'(i)});
      steps.push_back('{OP_READ_STATUS, 8'h00, 32'h0000_0004});
      steps.push_back('{OP_SEND_BAD, 8'h55, 32'h0});
      steps.push_back('{OP_READ_STATUS, 8'h00, 32'h0000_0005});
      steps.push_back('{OP_GLITCH, 8'h00, 32'h0});
      steps.push_back('{OP_READ_STATUS, 8'h00, 32'h0000_0004});
      steps.push_back('{OP_SEND, 8'hF8, 32'h0});
      steps.push_back('{OP_SEND, 8'h80, 32'h0});
      steps.push_back('{OP_READ_STATUS, 8'h00, FILTER ? 32'h0000_0100 : 32'h0000_0200});
      steps.push_back('{OP_READ_DATA, 8'h00, FILTER ? 32'h0000_0180 : 32'h0000_01F8});
      steps.push_back('{OP_READ_DATA, 8'h00, FILTER ? 32'h0000_0000 : 32'h0000_0180});
      for (int i = 0; i < 5; i++) steps.push_back('{OP_SEND, 8'h11 + 8'(i), 32'h0});
      steps.push_back('{OP_READ_STATUS, 8'h00, 32'h0000_0500});
      steps.push_back('{OP_FLUSH, 8'h00, 32'h0});
      steps.push_back('{OP_READ_STATUS, 8'h00, 32'h0000_0004});

      #1;
      check_output("reset_rd_data", rd_data, 32'h0);
      check_output("reset_hit", {31'b0, hit}, 32'h0);
      tick(3);
      reset = 1'b0;
      tick(4);

      for (int i = 0; i < steps.size(); i++) apply_stimulus(steps[i], i);

      // hit is high for exactly one cycle after a load; other addresses never hit.
      read_reg(STAT, d, h);
      check_output("hit_status", {31'b0, h}, 32'h1);
      tick(1);
      check_output("hit_drop", {31'b0, hit}, 32'h0);
      check_output("rd_data_idle", rd_data, 32'h0);
      read_reg(12'h123, d, h);
      check_output("other_addr_hit", {31'b0, h}, 32'h0);
      check_output("other_addr_data", d, 32'h0);

      // Reset in the middle of a byte: FIFO and outputs cleared, next byte clean.
      send_frame(8'h42, 1'b1);
      midi_rx = 1'b0;
      tick(CPB);
      midi_rx = 1'b1;
      tick(CPB);
      midi_rx = 1'b0;
      tick(CPB);
      addr  = STAT;
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      check_output("pre_reset_status", rd_data, 32'h0000_0100);
      reset = 1'b1;
      midi_rx = 1'b1;
      #2;
      check_output("midreset_rd_data", rd_data, 32'h0);
      check_output("midreset_hit", {31'b0, hit}, 32'h0);
      tick(3);
      reset = 1'b0;
      tick(2 * CPB);
      read_reg(STAT, d, h);
      check_output("post_reset_status", d, 32'h0000_0004);
      send_frame(8'hA5, 1'b1);
      read_reg(BASE, d, h);
      check_output("post_reset_byte", d, 32'h0000_01A5);

      // Randomized traffic against the queue model.
      model_q.delete();
      model_ovr = 1'b0;
      model_fe  = 1'b0;
      for (int it = 0; it < 70; it++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 4) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) b = 8'hF8 | 8'($urandom_range(0, 7));
            send_frame(b, 1'b1);
            model_send(b);
         end else if (r == 5) begin
            send_frame(8'($urandom_range(0, 255)), 1'b0);
            model_fe = 1'b1;
         end else if (r == 6 || r == 8) begin
            e = (model_q.size() != 0) ? {23'b0, 1'b1, model_q.pop_front()} : 32'h0;
            read_reg(BASE, d, h);
            check_output($sformatf("rand%0d_data", it), d, e);
         end else if (r == 9 && $urandom_range(0, 2) == 0) begin
            write_reg(STAT, 32'h1);
            model_q.delete();
         end else begin
            e = model_status();
            model_ovr = 1'b0;
            model_fe  = 1'b0;
            read_reg(STAT, d, h);
            check_output($sformatf("rand%0d_status", it), d, e);
         end
      end
      e = model_status();
      read_reg(STAT, d, h);
      check_output("rand_final_status", d, e);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
